// File: rtl/mixcol_engine.sv
// Sequential MixColumns / InvMixColumns engine: reads one 4-byte state column from the
// vector register file, transforms it in GF(2^8) and writes it back, for all 4 columns.
`timescale 1ns/1ps
module mixcol_engine #(
  parameter bit INV_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        inv,
  input  logic [3:0]  base_row,
  output logic        busy,
  output logic        done,
  output logic [3:0]  rf_fila,
  output logic [1:0]  rf_columnar,
  output logic        rf_col_read,
  input  logic [31:0] rf_rdata,
  output logic [3:0]  rf_writeAddr,
  output logic [1:0]  rf_columnaw,
  output logic        rf_wr_en,
  output logic        rf_col_write,
  output logic [31:0] rf_wdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MIX   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  col_r, col_s;
  logic        inv_r, inv_s;
  logic [3:0]  base_r, base_s;
  logic [31:0] col_q_r;
  logic [31:0] res_q_r;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        rd_r, rd_s;
  logic        wr_r, wr_s;
  logic [3:0]  fila_r, fila_s;
  logic [1:0]  columnar_r, columnar_s;
  logic [3:0]  waddr_r, waddr_s;
  logic [1:0]  columnaw_r, columnaw_s;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit coefficient as a sum of b, 2b, 4b, 8b selected by its bits.
  function automatic logic [7:0] gf_mul_coef(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c, input logic inv_sel);
    logic [7:0] a0, a1, a2, a3;
    logic [3:0] k0, k1, k2, k3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    if (inv_sel) begin
      k0 = 4'he; k1 = 4'hb; k2 = 4'hd; k3 = 4'h9;
    end else begin
      k0 = 4'h2; k1 = 4'h3; k2 = 4'h1; k3 = 4'h1;
    end
    b0 = gf_mul_coef(a0, k0) ^ gf_mul_coef(a1, k1) ^ gf_mul_coef(a2, k2) ^ gf_mul_coef(a3, k3);
    b1 = gf_mul_coef(a1, k0) ^ gf_mul_coef(a2, k1) ^ gf_mul_coef(a3, k2) ^ gf_mul_coef(a0, k3);
    b2 = gf_mul_coef(a2, k0) ^ gf_mul_coef(a3, k1) ^ gf_mul_coef(a0, k2) ^ gf_mul_coef(a1, k3);
    b3 = gf_mul_coef(a3, k0) ^ gf_mul_coef(a0, k1) ^ gf_mul_coef(a1, k2) ^ gf_mul_coef(a2, k3);
    return {b0, b1, b2, b3};
  endfunction

  // State and per-block context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      col_r   <= 2'd0;
      inv_r   <= 1'b0;
      base_r  <= 4'd0;
    end else begin
      state_r <= state_s;
      col_r   <= col_s;
      inv_r   <= inv_s;
      base_r  <= base_s;
    end
  end

  // Next-state and next-context logic.
  always_comb begin
    state_s = state_r;
    col_s   = col_r;
    inv_s   = inv_r;
    base_s  = base_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = READ;
          col_s   = 2'd0;
          inv_s   = inv & INV_EN;
          base_s  = {base_row[3:2], 2'b00};
        end else begin
          state_s = IDLE;
        end
      end
      READ:  state_s = MIX;
      MIX:   state_s = WRITE;
      WRITE: begin
        if (col_r == 2'd3) begin
          state_s = DONE;
        end else begin
          col_s   = col_r + 2'd1;
          state_s = READ;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they are registered yet valid in-state.
  always_comb begin
    busy_s     = 1'b0;
    done_s     = 1'b0;
    rd_s       = 1'b0;
    wr_s       = 1'b0;
    fila_s     = fila_r;
    columnar_s = columnar_r;
    waddr_s    = waddr_r;
    columnaw_s = columnaw_r;
    case (state_s)
      READ: begin
        busy_s     = 1'b1;
        rd_s       = 1'b1;
        fila_s     = base_s;
        columnar_s = col_s;
      end
      MIX:  busy_s = 1'b1;
      WRITE: begin
        busy_s     = 1'b1;
        wr_s       = 1'b1;
        waddr_s    = base_s;
        columnaw_s = col_s;
      end
      DONE:    done_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rd_r       <= 1'b0;
      wr_r       <= 1'b0;
      fila_r     <= 4'd0;
      columnar_r <= 2'd0;
      waddr_r    <= 4'd0;
      columnaw_r <= 2'd0;
    end else begin
      busy_r     <= busy_s;
      done_r     <= done_s;
      rd_r       <= rd_s;
      wr_r       <= wr_s;
      fila_r     <= fila_s;
      columnar_r <= columnar_s;
      waddr_r    <= waddr_s;
      columnaw_r <= columnaw_s;
    end
  end

  // Column capture in READ and GF transform in MIX; res_q_r doubles as the write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q_r <= 32'd0;
      res_q_r <= 32'd0;
    end else begin
      if (state_r == READ) begin
        col_q_r <= rf_rdata;
      end
      if (state_r == MIX) begin
        res_q_r <= mix_column(col_q_r, inv_r);
      end
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign rf_col_read  = rd_r;
  assign rf_fila      = fila_r;
  assign rf_columnar  = columnar_r;
  assign rf_wr_en     = wr_r;
  assign rf_col_write = wr_r;
  assign rf_writeAddr = waddr_r;
  assign rf_columnaw  = columnaw_r;
  assign rf_wdata     = res_q_r;

endmodule
